// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin between fetch and data requesters,
// single outstanding transfer with fixed read latency.
module mem_arbiter #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       f_gnt,
  output logic       d_gnt,
  output logic       f_done,
  output logic       d_done,
  output logic [7:0] rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       last_d, last_d_nx;
  logic       wr, wr_nx;
  logic [7:0] addr_nx, wdata_nx, rdata_nx;
  logic       we_nx, f_gnt_nx, d_gnt_nx, f_done_nx, d_done_nx;
  logic       pick_d;

  // Data wins only when fetch is idle or fetch was served last.
  assign pick_d = d_req && (!f_req || !last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b1;
      wr        <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last_d    <= last_d_nx;
      wr        <= wr_nx;
      mem_addr  <= addr_nx;
      mem_wdata <= wdata_nx;
      mem_we    <= we_nx;
      f_gnt     <= f_gnt_nx;
      d_gnt     <= d_gnt_nx;
      f_done    <= f_done_nx;
      d_done    <= d_done_nx;
      rdata     <= rdata_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    last_d_nx = last_d;
    wr_nx     = wr;
    addr_nx   = mem_addr;
    wdata_nx  = mem_wdata;
    we_nx     = 1'b0;
    f_gnt_nx  = f_gnt;
    d_gnt_nx  = d_gnt;
    f_done_nx = 1'b0;
    d_done_nx = 1'b0;
    rdata_nx  = rdata;
    unique case (state)
      IDLE: begin
        if (f_req || d_req) begin
          state_nx  = WAIT;
          cnt_nx    = LAT_M1;
          last_d_nx = pick_d;
          if (pick_d) begin
            d_gnt_nx = 1'b1;
            addr_nx  = d_addr;
            wr_nx    = d_we;
            we_nx    = d_we;
            if (d_we) wdata_nx = d_wdata;
          end else begin
            f_gnt_nx = 1'b1;
            addr_nx  = f_addr;
            wr_nx    = 1'b0;
          end
        end
      end
      WAIT: begin
        if (wr) begin
          d_done_nx = 1'b1;
          state_nx  = DONE;
        end else if (cnt == 3'd0) begin
          rdata_nx  = mem_rdata;
          f_done_nx = f_gnt;
          d_done_nx = d_gnt;
          state_nx  = DONE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        f_gnt_nx = 1'b0;
        d_gnt_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 2, meaning cycles from mem_addr registered to mem_rdata valid (legal range 1..7).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch unit read request, level, held until f_done
- f_addr  in  8  fetch address
- d_req  in  1  data unit request, level, held until d_done
- d_we  in  1  data request is write (1) or read (0)
- d_addr  in  8  data address
- d_wdata  in  8  data write value
- mem_rdata  in  8  memory read data
- mem_addr  out  8  memory address, registered
- mem_wdata  out  8  memory write data, registered
- mem_we  out  1  memory write strobe, registered
- f_gnt, d_gnt  out  1 each  port currently owns memory
- f_done, d_done  out  1 each  one-cycle completion pulse
- rdata  out  8  captured read data, shared by both ports

Function
REQ-003 The block SHALL implement states IDLE, WAIT, DONE in a registered FSM.
REQ-004 In IDLE with at least one req high at a rising edge, the block SHALL grant one port, register mem_addr from that port's address, set its gnt, and enter WAIT.
REQ-005 When both reqs are high in IDLE, the block SHALL grant the port not granted last (round-robin); last-grant SHALL reset to data, so fetch wins the first tie.
REQ-006 With a single req high, the block SHALL grant it regardless of last-grant.
REQ-007 On a data write grant, the block SHALL register mem_wdata=d_wdata and mem_we=1 for exactly one cycle; fetch grants and data reads SHALL leave mem_we=0.
REQ-008 On a read, a down-counter loaded with READ_LAT-1 at grant SHALL decrement in WAIT; at the edge where it is 0, the block SHALL capture mem_rdata into rdata, pulse the granted port's done, and enter DONE.
REQ-009 On a write, the block SHALL pulse d_done at the first WAIT edge (one cycle after grant) and enter DONE; rdata SHALL be unchanged.
REQ-010 Read latency SHALL be READ_LAT cycles from grant edge to done high (2 by default); write latency SHALL be 1 cycle.
REQ-011 done SHALL be high exactly one cycle, coincident with DONE; gnt SHALL remain high through DONE and clear on the DONE->IDLE edge.
REQ-012 DONE SHALL always advance to IDLE after one cycle, ignoring reqs; requesters SHALL drop or re-issue req during DONE.
REQ-013 The block SHALL ignore addr, we, wdata changes after the grant edge; the latched values SHALL be used for the whole transfer.
REQ-014 If a req drops mid-transfer, the block SHALL complete the transfer and still pulse done.
REQ-015 mem_addr and mem_wdata SHALL hold their last values between transfers; rdata SHALL hold until the next read completes.
REQ-016 At most one gnt and one done SHALL be high in any cycle.

Reset
REQ-017 rst_n low SHALL immediately force state=IDLE, counter=0, last-grant=data, mem_addr=0, mem_wdata=0, mem_we=0, f_gnt=d_gnt=0, f_done=d_done=0, rdata=0.
REQ-018 Reset asserted mid-transfer SHALL abort it without any done pulse; mem_we SHALL fall asynchronously.
REQ-019 After rst_n rises, the first rising edge with a req high SHALL be treated as an IDLE grant.

Verification
REQ-020 Fetch read: f_req=1, f_addr=0x10, memory returns 0x2B -> f_gnt next cycle, mem_addr=0x10, f_done one cycle 2 cycles after grant, rdata=0x2B.
REQ-021 Data write: d_req=1, d_we=1, d_addr=0x80, d_wdata=0x55 -> mem_we high one cycle with mem_addr=0x80, mem_wdata=0x55; d_done next cycle; rdata unchanged.
REQ-022 Simultaneous f_req and d_req after reset -> fetch served first, then data after DONE; repeat both held -> grants alternate F,D,F,D.
REQ-023 Reset pulsed during WAIT of a read -> no done, all outputs 0; after release, a pending f_req is granted normally.
REQ-024 Address changed to 0xFF one cycle after grant at 0x20 -> mem_addr stays 0x20 for the whole transfer.
REQ-025 READ_LAT=3 build: fetch read -> f_done 3 cycles after grant; rdata matches memory contents.
